// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and bit-period arithmetic,
// common to the transmitter and receiver.
package uart_pkg;

    typedef logic [2:0] uart_state_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam int BIT_CNT_W = 16;

    function automatic int calc_clk_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// Double-buffered UART transmitter: 8 data bits LSB first, optional parity,
// one or two stop bits; back-to-back frames without an idle gap.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 5000000,
    parameter int BAUD_RATE  = 9600,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    output logic       tx_data_ready,
    output logic       tx_pin,
    output logic       tx_busy
);

    localparam int CLK_PER_BIT = calc_clk_per_bit(CLK_FREQ, BAUD_RATE);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(CLK_PER_BIT - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    generate
        if (CLK_PER_BIT < 2 || CLK_PER_BIT > 65535) begin : g_bad_clk_per_bit
            $error("uart_tx: CLK_PER_BIT must lie in 2..65535");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
            $error("uart_tx: STOP_BITS must be 1 or 2");
        end
    endgenerate

    uart_state_t          state_reg;
    logic [BIT_CNT_W-1:0] bit_cnt_reg;
    logic [2:0]           bit_idx_reg;
    logic [7:0]           hold_reg;
    logic                 hold_full_reg;
    logic [7:0]           shift_reg;
    logic                 parity_reg;
    logic                 tx_pin_reg;
    logic                 tx_busy_reg;

    logic bit_done;
    logic stop_done;
    logic load;
    logic accept;

    assign bit_done  = (bit_cnt_reg == BIT_LAST);
    assign stop_done = (state_reg == ST_STOP) && bit_done && (bit_idx_reg == STOP_LAST);
    // The holding register empties into the shifter whenever a frame can begin.
    assign load      = hold_full_reg && ((state_reg == ST_IDLE) || stop_done);
    assign accept    = tx_data_valid && !hold_full_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= '0;
            bit_idx_reg   <= '0;
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
            shift_reg     <= '0;
            parity_reg    <= 1'b0;
            tx_pin_reg    <= 1'b1;
            tx_busy_reg   <= 1'b0;
        end else begin
            if (load) begin
                shift_reg     <= hold_reg;
                parity_reg    <= (^hold_reg) ^ (PARITY_ODD != 0);
                hold_full_reg <= 1'b0;
            end else if (accept) begin
                hold_reg      <= tx_data;
                hold_full_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    bit_cnt_reg <= '0;
                    bit_idx_reg <= '0;
                    if (load) begin
                        state_reg   <= ST_START;
                        tx_pin_reg  <= 1'b0;
                        tx_busy_reg <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_done) begin
                        state_reg   <= ST_DATA;
                        bit_cnt_reg <= '0;
                        bit_idx_reg <= '0;
                        tx_pin_reg  <= shift_reg[0];
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        bit_cnt_reg <= '0;
                        if (bit_idx_reg == 3'd7) begin
                            bit_idx_reg <= '0;
                            if (PARITY_EN != 0) begin
                                state_reg  <= ST_PARITY;
                                tx_pin_reg <= parity_reg;
                            end else begin
                                state_reg  <= ST_STOP;
                                tx_pin_reg <= 1'b1;
                            end
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 1'b1;
                            shift_reg   <= shift_reg >> 1;
                            tx_pin_reg  <= shift_reg[1];
                        end
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (bit_done) begin
                        state_reg   <= ST_STOP;
                        bit_cnt_reg <= '0;
                        bit_idx_reg <= '0;
                        tx_pin_reg  <= 1'b1;
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    end
                end
                ST_STOP: begin
                    // bit_idx_reg counts stop bits here so the cycle counter stays 16 bits wide.
                    if (bit_done) begin
                        bit_cnt_reg <= '0;
                        if (bit_idx_reg == STOP_LAST) begin
                            bit_idx_reg <= '0;
                            if (load) begin
                                state_reg  <= ST_START;
                                tx_pin_reg <= 1'b0;
                            end else begin
                                state_reg   <= ST_IDLE;
                                tx_busy_reg <= 1'b0;
                            end
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 1'b1;
                        end
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    bit_cnt_reg <= '0;
                    bit_idx_reg <= '0;
                    tx_pin_reg  <= 1'b1;
                    tx_busy_reg <= 1'b0;
                end
            endcase
        end
    end

    assign tx_data_ready = !hold_full_reg;
    assign tx_pin        = tx_pin_reg;
    assign tx_busy       = tx_busy_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four parameter variants on one clock, compared every cycle
// against a frame-timeline model, plus table vectors and multi-cycle corner cases.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int NI    = 4;
    localparam int CPB   = 10;
    localparam int DEPTH = 16384;
    localparam int PEN  [NI] = '{0, 1, 1, 0};
    localparam int PODD [NI] = '{0, 0, 1, 0};
    localparam int SB   [NI] = '{1, 1, 1, 2};

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    data [NI];
    logic [NI-1:0] valid = '0;
    logic [NI-1:0] ready;
    logic [NI-1:0] pin;
    logic [NI-1:0] busy;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            uart_tx #(
                .CLK_FREQ  (1000000),
                .BAUD_RATE (100000),
                .PARITY_EN (PEN[gi]),
                .PARITY_ODD(PODD[gi]),
                .STOP_BITS (SB[gi])
            ) dut (
                .clk          (clk),
                .rst_n        (rst_n),
                .tx_data      (data[gi]),
                .tx_data_valid(valid[gi]),
                .tx_data_ready(ready[gi]),
                .tx_pin       (pin[gi]),
                .tx_busy      (busy[gi])
            );
        end
    endgenerate

    // Expected outputs after each rising edge, stored so that zero means idle.
    bit         exp_pin_low   [NI][DEPTH];
    bit         exp_busy      [NI][DEPTH];
    bit         exp_not_ready [NI][DEPTH];
    int         free_at  [NI] = '{default: 0};
    int         start_at [NI] = '{default: 0};
    int         acc_cnt  [NI] = '{default: 0};
    int         edge_n = 0;
    int         checks = 0;
    int         errors = 0;
    logic       prev_pin0 = 1'b1;
    int         fall_prev = -1;
    int         fall_last = -1;

    typedef struct {
        int         inst;
        logic [7:0] d;
        logic [11:0] line;
        int         nbits;
        int         len;
    } vec_t;
    vec_t vecs [8];

    function automatic int frame_bits(input int i);
        return 1 + 8 + PEN[i] + SB[i];
    endfunction

    function automatic bit line_bit(input int i, input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (PEN[i] != 0 && b == 9) return (^d) ^ (PODD[i] != 0);
        return 1'b1;
    endfunction

    // Frames leave in acceptance order; each starts one edge after its handshake
    // or on the edge that ends the previous frame, whichever is later.
    task automatic model_step();
        int k;
        int s;
        int len;
        k = edge_n + 1;
        if (k >= DEPTH - 1) begin
            $display("FAIL run_length: edge %0d exceeds model depth %0d", k, DEPTH);
            $fatal(1);
        end
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                for (int j = k; j <= free_at[i] && j < DEPTH; j++) begin
                    exp_pin_low[i][j]   = 1'b0;
                    exp_busy[i][j]      = 1'b0;
                    exp_not_ready[i][j] = 1'b0;
                end
                free_at[i] = k;
            end else if (valid[i] && !exp_not_ready[i][k-1]) begin
                s   = (free_at[i] > k + 1) ? free_at[i] : k + 1;
                len = frame_bits(i) * CPB;
                for (int j = k; j < s && j < DEPTH; j++) exp_not_ready[i][j] = 1'b1;
                for (int j = s; j < s + len && j < DEPTH; j++) begin
                    exp_pin_low[i][j] = !line_bit(i, data[i], (j - s) / CPB);
                    exp_busy[i][j]    = 1'b1;
                end
                free_at[i]  = s + len;
                start_at[i] = s;
                acc_cnt[i]  = acc_cnt[i] + 1;
            end
        end
        edge_n = k;
    endtask

    task automatic sb_compare();
        if (edge_n >= 1) begin
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (pin[i] !== !exp_pin_low[i][edge_n] || busy[i] !== exp_busy[i][edge_n] ||
                    ready[i] !== !exp_not_ready[i][edge_n]) begin
                    errors++;
                    $display("FAIL cycle u%0d edge %0d: pin/busy/ready got %b%b%b want %b%b%b", i, edge_n,
                             pin[i], busy[i], ready[i], !exp_pin_low[i][edge_n], exp_busy[i][edge_n],
                             !exp_not_ready[i][edge_n]);
                end
            end
        end
        if (prev_pin0 === 1'b1 && pin[0] === 1'b0) begin
            fall_prev = fall_last;
            fall_last = edge_n;
        end
        prev_pin0 = pin[0];
    endtask

    task automatic check1(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b want %b (edge %0d)", name, got, want, edge_n);
        end
    endtask

    task automatic checkn(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic wait_to(input int e);
        while (edge_n < e) @(negedge clk);
    endtask

    task automatic wait_idle(input int i);
        while (edge_n < free_at[i] + 1) @(negedge clk);
    endtask

    task automatic wait_acc(input int i, output int a);
        int c0;
        int t;
        c0 = acc_cnt[i];
        t  = 0;
        while (acc_cnt[i] == c0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (acc_cnt[i] == c0) begin
            errors++;
            $display("FAIL accept u%0d: no handshake within 300 cycles", i);
        end
        a = edge_n;
    endtask

    task automatic send(input int i, input logic [7:0] d, output int a);
        data[i]  = d;
        valid[i] = 1'b1;
        wait_acc(i, a);
        valid[i] = 1'b0;
    endtask

    initial begin
        int a;
        int a2;
        int i;
        int lows;
        int t;
        int c0;
        logic [7:0] bp_byte;
        logic [7:0] got;

        vecs[0] = '{0, 8'hA5, 12'h34A, 10, 100};
        vecs[1] = '{1, 8'h07, 12'h60E, 11, 110};
        vecs[2] = '{2, 8'h07, 12'h40E, 11, 110};
        vecs[3] = '{3, 8'h55, 12'h6AA, 11, 110};
        vecs[4] = '{0, 8'h00, 12'h200, 10, 100};
        vecs[5] = '{0, 8'hFF, 12'h3FE, 10, 100};
        vecs[6] = '{1, 8'h55, 12'h4AA, 11, 110};
        vecs[7] = '{2, 8'h00, 12'h600, 11, 110};
        for (int k = 0; k < NI; k++) data[k] = 8'h00;

        fork
            forever begin
                @(posedge clk);
                model_step();
            end
            forever begin
                @(negedge clk);
                sb_compare();
            end
        join_none

        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check1($sformatf("reset_pin_u%0d", k), pin[k], 1'b1);
            check1($sformatf("reset_busy_u%0d", k), busy[k], 1'b0);
            check1($sformatf("reset_ready_u%0d", k), ready[k], 1'b1);
        end
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            i = vecs[v].inst;
            wait_idle(i);
            send(i, vecs[v].d, a);
            check1($sformatf("v%0d_idle_at_accept", v), pin[i], 1'b1);
            @(negedge clk);
            check1($sformatf("v%0d_start_latency", v), pin[i], 1'b0);
            check1($sformatf("v%0d_busy_rise", v), busy[i], 1'b1);
            for (int b = 0; b < vecs[v].nbits; b++) begin
                wait_to(a + 1 + b * CPB + CPB / 2);
                check1($sformatf("v%0d_bit%0d", v, b), pin[i], vecs[v].line[b]);
            end
            wait_to(a + vecs[v].len);
            check1($sformatf("v%0d_busy_last", v), busy[i], 1'b1);
            wait_to(a + vecs[v].len + 1);
            check1($sformatf("v%0d_busy_fall", v), busy[i], 1'b0);
        end

        // Back-to-back with valid held high across both handshakes.
        wait_idle(0);
        data[0]  = 8'h00;
        valid[0] = 1'b1;
        wait_acc(0, a);
        check1("b2b_ready_low", ready[0], 1'b0);
        data[0] = 8'hFF;
        wait_acc(0, a2);
        valid[0] = 1'b0;
        checkn("b2b_accept_gap", a2 - a, 2);
        wait_to(a + 205);
        checkn("b2b_first_start", fall_prev, a + 1);
        checkn("b2b_start_spacing", fall_last - fall_prev, 100);

        // Reset in the 45th cycle of a frame, with a second byte waiting.
        wait_idle(0);
        send(0, 8'hC3, a);
        send(0, 8'h3C, a2);
        wait_to(a + 45);
        rst_n = 1'b0;
        @(negedge clk);
        check1("midreset_pin", pin[0], 1'b1);
        check1("midreset_busy", busy[0], 1'b0);
        check1("midreset_ready", ready[0], 1'b1);
        rst_n = 1'b1;
        lows  = 0;
        repeat (150) begin
            @(negedge clk);
            if (pin[0] !== 1'b1 || busy[0] !== 1'b0) lows++;
        end
        checkn("midreset_no_resume", lows, 0);

        // Backpressure: data churns every cycle while the holding register is full.
        wait_idle(0);
        send(0, 8'h81, a);
        send(0, 8'h7E, a2);
        bp_byte  = 8'($urandom);
        data[0]  = bp_byte;
        valid[0] = 1'b1;
        c0 = acc_cnt[0];
        t  = 0;
        while (acc_cnt[0] == c0 && t < 300) begin
            @(negedge clk);
            t++;
            if (acc_cnt[0] == c0) begin
                bp_byte = 8'($urandom);
                data[0] = bp_byte;
            end
        end
        valid[0] = 1'b0;
        checkn("bp_handshake", acc_cnt[0] - c0, 1);
        for (int b = 0; b < 8; b++) begin
            wait_to(start_at[0] + CPB * (b + 1) + CPB / 2);
            got[b] = pin[0];
        end
        checkn("bp_byte", int'(got), int'(bp_byte));

        // Random traffic across all variants, judged by the per-cycle model.
        for (int n = 0; n < 40; n++) begin
            i = $urandom_range(0, NI - 1);
            send(i, 8'($urandom), a);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        for (int k = 0; k < NI; k++) wait_idle(k);
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 5000000, clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, line bit rate.
REQ-003 SHALL have parameter PARITY_EN, default 0, 1 = append parity bit after data.
REQ-004 SHALL have parameter PARITY_ODD, default 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0.
REQ-005 SHALL have parameter STOP_BITS, default 1, legal values 1 or 2.
REQ-006 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port tx_data  input  8  byte to send, LSB first on the line.
REQ-009 SHALL have port tx_data_valid  input  1  producer offers tx_data.
REQ-010 SHALL have port tx_data_ready  output  1  holding register empty; byte accepted on valid&&ready at a rising edge.
REQ-011 SHALL have port tx_pin  output  1  serial line, idle high, registered.
REQ-012 SHALL have port tx_busy  output  1  high while a frame is on the line (START through last STOP).

Function
REQ-013 SHALL derive CLK_PER_BIT = CLK_FREQ/BAUD_RATE (integer division); each line bit SHALL last exactly CLK_PER_BIT cycles.
REQ-014 SHALL be double-buffered: an 8-bit holding register feeds an 8-bit shift register, so the next byte can be accepted while the current frame shifts.
REQ-015 SHALL deassert tx_data_ready in the cycle after acceptance, and reassert it in the cycle after the holding register transfers to the shifter.
REQ-016 SHALL ignore tx_data while tx_data_ready=0; tx_data_valid without ready SHALL have no effect.
REQ-017 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-018 SHALL go IDLE->START on the first edge on which the holding register is full: load the shifter, drive tx_pin=0, and set tx_busy=1.
REQ-019 SHALL drive tx_pin low one cycle after the accepting edge when starting from IDLE; this is the defined latency.
REQ-020 SHALL go START->DATA after CLK_PER_BIT cycles, then shift out 8 bits LSB first.
REQ-021 SHALL go DATA->PARITY after bit 7 when PARITY_EN=1; otherwise DATA->STOP.
REQ-022 SHALL compute the parity bit as XOR of the 8 data bits, inverted when PARITY_ODD=1.
REQ-023 SHALL hold tx_pin=1 for STOP_BITS*CLK_PER_BIT cycles in STOP.
REQ-024 SHALL, at the end of STOP, go directly to START on that same edge if the holding register is full (no idle gap); otherwise go to IDLE with tx_busy=0.
REQ-025 SHALL use a 16-bit bit-cycle counter and a 3-bit data-bit index; both SHALL clear on every state transition.
REQ-026 SHALL produce a frame length of (1+8+PARITY_EN+STOP_BITS)*CLK_PER_BIT cycles.
REQ-027 SHALL fail elaboration if CLK_PER_BIT < 2, CLK_PER_BIT > 65535, or STOP_BITS is not 1 or 2.

Reset
REQ-028 SHALL, while rst_n=0 at a rising edge, set tx_pin=1, tx_busy=0, tx_data_ready=1, FSM=IDLE, and clear counters, holding register and shifter.
REQ-029 SHALL, on reset asserted mid-frame, abandon the frame and drive tx_pin=1 from the next edge; no partial frame SHALL resume after reset.

Structure
REQ-030 SHALL take the FSM state encoding and the CLK_PER_BIT calculation from shared package uart_pkg, which uart_rx also uses.
REQ-031 SHALL keep the bit-period counter inline; no sub-module is required. An optional uart_baud_gen tick generator is permitted if it is shared with uart_rx.

Verification (bench: CLK_FREQ=1000000, BAUD_RATE=100000, CLK_PER_BIT=10)
REQ-032 SHALL cover single byte: send 0xA5, PARITY_EN=0 -> tx_pin low 1 cycle after the handshake, then bits 1,0,1,0,0,1,0,1 each 10 cycles, then high 10 cycles; tx_busy high 100 cycles.
REQ-033 SHALL cover back-to-back: 0x00 then 0xFF, with valid held high -> second start bit begins exactly 100 cycles after the first; no idle gap; ready low between accepts.
REQ-034 SHALL cover parity: PARITY_EN=1 with 0x07 -> even parity bit 1; with PARITY_ODD=1 -> parity bit 0; frame 110 cycles.
REQ-035 SHALL cover two stop bits: STOP_BITS=2 with 0x55 -> line high 20 cycles after bit 7; tx_busy drops at cycle 110.
REQ-036 SHALL cover reset mid-frame: rst_n low at cycle 45 of a frame -> tx_pin=1, tx_busy=0, tx_data_ready=1 at the next edge; line stays idle afterward.
REQ-037 SHALL cover backpressure: valid asserted while ready=0 with a changing tx_data -> only the byte present at the accepting edge is transmitted.
